// File: rtl/sdpb_stream_reader.sv
// Read-side controller for the SDPB buffer. It issues port-B reads and returns the words as a
// valid/ready stream. A 2-entry skid FIFO catches the one-cycle-late RAM data under backpressure.
module sdpb_stream_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              rd_ceb,
  output logic              rd_oce,
  output logic [ADDR_W-1:0] rd_adb,
  input  logic [DATA_W-1:0] rd_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  issue_cnt, out_cnt;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wptr, rptr;
  logic [1:0]        fifo_cnt;
  logic              done_q;

  logic       pop, issue, accept, zero_req, finish, abort_run;
  logic [2:0] occ_after;

  assign pop       = m_valid & m_ready;
  assign abort_run = (state == RUN) & abort;
  assign accept    = (state == IDLE) & start & ~abort & (length != '0);
  assign zero_req  = (state == IDLE) & start & ~abort & (length == '0);
  assign finish    = (state == RUN) & ~abort & pop & (out_cnt == LEN_W'(1));

  // Occupancy (FIFO words + read in flight) after this cycle's pop must leave room for one more.
  assign occ_after = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = (state == RUN) & ~abort & (issue_cnt != '0) & (occ_after < 3'd2);

  assign rd_ceb  = issue;
  assign rd_oce  = 1'b1;
  assign rd_adb  = addr;
  assign m_valid = (fifo_cnt != 2'd0);
  assign m_data  = fifo_mem[rptr];
  assign m_last  = m_valid & (out_cnt == LEN_W'(1));
  assign busy    = (state == RUN);
  assign done    = done_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (abort || finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      issue_cnt   <= '0;
      out_cnt     <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      fifo_cnt    <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= finish | zero_req;

      if (accept) begin
        addr      <= start_addr;
        issue_cnt <= length;
        out_cnt   <= length;
      end else if (issue) begin
        addr      <= addr + ADDR_W'(1);
        issue_cnt <= issue_cnt - LEN_W'(1);
      end
      if (pop && state == RUN && !abort) out_cnt <= out_cnt - LEN_W'(1);

      // Abort drops queued words and the read still coming back from the RAM.
      inflight <= issue;
      if (abort_run) begin
        wptr     <= 1'b0;
        rptr     <= 1'b0;
        fifo_cnt <= 2'd0;
      end else begin
        if (inflight) begin
          fifo_mem[wptr] <= rd_dout;
          wptr           <= ~wptr;
        end
        if (pop) rptr <= ~rptr;
        fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
      end
    end
  end

endmodule

// File: doc/sdpb_stream_reader.md
Name: sdpb_stream_reader

Overview:
- Read-side controller for the 64-bit-write / 16-bit-read SDPB buffer.
- Takes a start address and a word count, issues read addresses on SDPB port B, and returns the 16-bit words as a valid/ready stream with a last-word flag.
- Sits between the SDPB read port and downstream consumers (serializer, host readout), and absorbs backpressure without losing RAM read data.

Parameters:
- ADDR_W, 9: port-B address width (512 x 16-bit words).
- DATA_W, 16: port-B data width.
- LEN_W, 10: word-count width.

Ports:
- clk  in  1  single clock; drives this block and SDPB clkb.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- start_addr  in  ADDR_W  first word address.
- length  in  LEN_W  words to read; 0 means no reads.
- abort  in  1  synchronous cancel.
- rd_ceb  out  1  SDPB port-B clock enable (read strobe).
- rd_oce  out  1  SDPB output clock enable; constant 1.
- rd_adb  out  ADDR_W  SDPB port-B address.
- rd_dout  in  DATA_W  SDPB port-B data; valid the cycle after the edge that sampled rd_ceb=1 (bypass read mode).
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word of the request.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
Reset:
- rst_n=0 at an edge puts the block in IDLE.
- After reset: rd_ceb=0, rd_adb=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0; FIFO empty; in-flight flag cleared.
- rd_oce=1 always.
- Reset mid-request drops all pending and in-flight words silently.

States:
- IDLE:
  - start=1 with length!=0: latch addr=start_addr, issue_cnt=length, out_cnt=length; go to RUN; busy=1 from the next cycle.
  - start=1 with length=0: done=1 for one cycle (the cycle after start); stay IDLE; no reads issued.
- RUN: reads are issued and words delivered; go to IDLE when the final word handshakes.

Read issue (RUN only):
- rd_ceb=1 when issue_cnt>0 and (fifo_cnt + inflight - pop) < 2.
- pop = m_valid & m_ready.
- On issue: rd_adb=addr, addr increments mod 2^ADDR_W (511 wraps to 0), issue_cnt decrements.
- inflight is set on an issue edge and cleared the following edge, when rd_dout is written into the FIFO.

Output buffer:
- 2-entry FIFO. m_valid=FIFO non-empty; m_data=head.
- m_data is held stable while m_valid=1 and m_ready=0.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.

Last word and completion:
- m_last=1 exactly when the head is the word with out_cnt==1.
- Each pop decrements out_cnt.
- The pop at out_cnt==1 returns the block to IDLE: busy=0 and done=1 for one cycle, both on the following cycle.

Latency and throughput:
- start is sampled at edge E0; rd_ceb=1 in the following cycle.
- m_valid first rises after edge E0+2.
- With m_ready held at 1: one word per clock, so N words finish with done asserted at cycle E0+N+2.

Length:
- Values up to 1023 are allowed.
- Addresses wrap and re-read from the start of the RAM.

Abort:
- abort=1 in RUN: next cycle IDLE, FIFO flushed, m_valid=0, busy=0, done stays 0; any in-flight read data is discarded.
- abort in IDLE has no effect.
- abort and start in the same cycle: abort wins and the request is not accepted.

Start while busy:
- Ignored; no queueing.

Test Plan:
- Single request: RAM[k]=0x1000+k; start_addr=5, length=4, m_ready=1.
  - rd_adb sequence 5,6,7,8 on consecutive cycles.
  - m_data 0x1005..0x1008, with m_valid starting 2 cycles after start.
  - m_last on 0x1008; done one cycle later.
- Backpressure: length=8, m_ready toggling 1,0,0,1,...
  - All 8 words delivered in order, none duplicated or dropped.
  - m_data stable while stalled; fifo_cnt+inflight never exceeds 2.
- Wrap: start_addr=510, length=4.
  - rd_adb 510,511,0,1; data matches RAM; m_last on word 4.
- length=0: no rd_ceb, m_valid stays 0, done pulses once the cycle after start, busy stays 0.
- Abort: length=16, m_ready=0 after 3 words, abort pulsed.
  - Next cycle m_valid=0, busy=0, done=0.
  - A following start (addr 0, length 2) delivers RAM[0], RAM[1] only.
- Reset mid-run: rst_n=0 for one cycle during a 32-word request.
  - All outputs return to reset values the next cycle.
  - A subsequent request behaves as in the single-request scenario.
